// File: rtl/beat_sequencer_if.sv
// ---------------------------------------------------------------------------
// beat_sequencer_if
//   Pattern-load channel between the pattern source (control/UI logic) and
//   beat_sequencer. A transfer happens on a rising clock edge where both
//   pat_valid and pat_ready are high.
//
//   Signals:
//     pat_valid  source -> sequencer  a new pattern is offered
//     pat_ready  sequencer -> source  the pattern can be accepted this cycle
//     pat_left   source -> sequencer  left-voice pattern, bit 3 = beat one
//     pat_right  source -> sequencer  right-voice pattern, same bit order
//
//   Modports:
//     master  pattern source side
//     slave   sequencer side
// ---------------------------------------------------------------------------
interface beat_sequencer_if;
    logic       pat_valid;
    logic       pat_ready;
    logic [3:0] pat_left;
    logic [3:0] pat_right;

    modport master (
        output pat_valid,
        output pat_left,
        output pat_right,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_left,
        input  pat_right,
        output pat_ready
    );
endinterface

// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
//   Plays a two-voice, four-beat drum bar at a programmable tempo. An active
//   left/right pattern drives the hits; a one-entry shadow (pending) pattern
//   is swapped in only on a beat-one fire, so a bar never mixes patterns.
//
//   Ports:
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   level; begins playback from IDLE
//     stop       in   level; returns to IDLE, wins over start
//     period     in   clock cycles per beat (0 behaves as 1)
//     pat        slave modport of beat_sequencer_if (pattern handshake)
//     left_hit   out  one-cycle pulse, left voice plays this beat
//     right_hit  out  one-cycle pulse, right voice plays this beat
//     beat_fire  out  one-cycle pulse on every beat
//     beat_idx   out  index of the most recently fired beat (0 = beat one)
//     bar_start  out  one-cycle pulse together with a beat-one fire
//     bar_cnt    out  completed bars since start, wraps mod 256
//     busy       out  high while playing
// ---------------------------------------------------------------------------
module beat_sequencer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] period,
    beat_sequencer_if.slave  pat,
    output logic             left_hit,
    output logic             right_hit,
    output logic             beat_fire,
    output logic [1:0]       beat_idx,
    output logic             bar_start,
    output logic [7:0]       bar_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;          // cycles left before the next fire
    logic [1:0]       next_idx_q, next_idx_d; // index the next fire will play
    logic             first_bar_q, first_bar_d;
    logic [3:0]       act_left_q, act_left_d;
    logic [3:0]       act_right_q, act_right_d;
    logic [3:0]       pend_left_q, pend_left_d;
    logic [3:0]       pend_right_q, pend_right_d;
    logic             pend_v_q, pend_v_d;

    logic [1:0]       beat_idx_d;
    logic [7:0]       bar_cnt_d;
    logic             left_hit_d, right_hit_d, beat_fire_d, bar_start_d;

    logic [DIV_W-1:0] period_m1;
    logic [3:0]       eff_left, eff_right;
    logic             take;

    // A zero period is clamped to one cycle per beat.
    assign period_m1 = (period == '0) ? '0 : period - ONE;

    // While playing, only one pattern may wait for the bar boundary.
    assign pat.pat_ready = (state_q == IDLE) || !pend_v_q;
    assign take          = pat.pat_valid && pat.pat_ready;
    assign busy          = (state_q == RUN);

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        next_idx_d   = next_idx_q;
        first_bar_d  = first_bar_q;
        act_left_d   = act_left_q;
        act_right_d  = act_right_q;
        pend_left_d  = pend_left_q;
        pend_right_d = pend_right_q;
        pend_v_d     = pend_v_q;
        beat_idx_d   = beat_idx;
        bar_cnt_d    = bar_cnt;
        left_hit_d   = 1'b0;
        right_hit_d  = 1'b0;
        beat_fire_d  = 1'b0;
        bar_start_d  = 1'b0;
        eff_left     = act_left_q;
        eff_right    = act_right_q;

        case (state_q)
            IDLE: begin
                // Nothing is playing, so a new pattern goes straight live.
                if (take) begin
                    act_left_d  = pat.pat_left;
                    act_right_d = pat.pat_right;
                end
                if (start && !stop) begin
                    state_d     = RUN;
                    cnt_d       = '0;     // first RUN cycle fires
                    next_idx_d  = 2'd0;
                    bar_cnt_d   = 8'd0;
                    first_bar_d = 1'b1;
                end
            end

            RUN: begin
                // ready is low whenever pending is full, so a transfer and a
                // swap never coincide; a transfer on a beat-one fire only
                // affects the following bar.
                if (take) begin
                    pend_left_d  = pat.pat_left;
                    pend_right_d = pat.pat_right;
                    pend_v_d     = 1'b1;
                end

                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d       = period_m1;
                    beat_fire_d = 1'b1;
                    beat_idx_d  = next_idx_q;
                    next_idx_d  = next_idx_q + 2'd1;

                    if (next_idx_q == 2'd0) begin
                        bar_start_d = 1'b1;
                        if (first_bar_q) begin
                            first_bar_d = 1'b0;
                        end else begin
                            bar_cnt_d = bar_cnt + 8'd1;
                        end
                        // The waiting pattern already plays on this beat.
                        if (pend_v_q) begin
                            eff_left    = pend_left_q;
                            eff_right   = pend_right_q;
                            act_left_d  = pend_left_q;
                            act_right_d = pend_right_q;
                            pend_v_d    = 1'b0;
                        end
                    end

                    // Beat one lives in bit 3: for a 2-bit index, ~idx == 3 - idx.
                    left_hit_d  = eff_left[~next_idx_q];
                    right_hit_d = eff_right[~next_idx_q];
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the pattern registers are a handful of flops, not a memory, so
    // they are reset along with everything else; reset discards pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            next_idx_q   <= 2'd0;
            first_bar_q  <= 1'b0;
            act_left_q   <= 4'd0;
            act_right_q  <= 4'd0;
            pend_left_q  <= 4'd0;
            pend_right_q <= 4'd0;
            pend_v_q     <= 1'b0;
            beat_idx     <= 2'd0;
            bar_cnt      <= 8'd0;
            left_hit     <= 1'b0;
            right_hit    <= 1'b0;
            beat_fire    <= 1'b0;
            bar_start    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            next_idx_q   <= next_idx_d;
            first_bar_q  <= first_bar_d;
            act_left_q   <= act_left_d;
            act_right_q  <= act_right_d;
            pend_left_q  <= pend_left_d;
            pend_right_q <= pend_right_d;
            pend_v_q     <= pend_v_d;
            beat_idx     <= beat_idx_d;
            bar_cnt      <= bar_cnt_d;
            left_hit     <= left_hit_d;
            right_hit    <= right_hit_d;
            beat_fire    <= beat_fire_d;
            bar_start    <= bar_start_d;
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// ---------------------------------------------------------------------------
// tb_beat_sequencer
//   Directed bench for beat_sequencer. Inputs change 1 ns after a rising edge
//   and outputs are sampled at the same point, so every sample reflects the
//   registers just updated by that edge.
// ---------------------------------------------------------------------------
module tb_beat_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic        left_hit, right_hit, beat_fire, bar_start, busy;
    logic [1:0]  beat_idx;
    logic [7:0]  bar_cnt;

    int n_checks = 0;
    int n_errors = 0;

    beat_sequencer_if pat_bus ();

    beat_sequencer #(.DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .pat       (pat_bus),
        .left_hit  (left_hit),
        .right_hit (right_hit),
        .beat_fire (beat_fire),
        .beat_idx  (beat_idx),
        .bar_start (bar_start),
        .bar_cnt   (bar_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] l, input logic [3:0] r);
        pat_bus.pat_valid = v;
        pat_bus.pat_left  = l;
        pat_bus.pat_right = r;
    endtask

    // Expects gap-1 quiet cycles, then a fire of beat idx with the given hits.
    // Compared vector: {beat_fire, beat_idx, left_hit, right_hit, bar_start}.
    task automatic beat(input string tag, input int gap, input logic [1:0] idx,
                        input logic l, input logic r);
        logic early;
        early = 1'b0;
        for (int i = 1; i < gap; i++) begin
            step();
            early = early | beat_fire;
        end
        if (gap > 1) check({tag, "_gap"}, 32'(early), 32'd0);
        step();
        check(tag, 32'({beat_fire, beat_idx, left_hit, right_hit, bar_start}),
              32'({1'b1, idx, l, r, (idx == 2'd0)}));
    endtask

    logic all_fire;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = 16'd4;
        offer(1'b0, 4'b0000, 4'b0000);

        // Reset values: everything low except pat_ready.
        #3;
        check("reset_outs", 32'({busy, beat_fire, beat_idx, left_hit, right_hit,
                                 bar_start, bar_cnt}), 32'd0);
        check("reset_ready", 32'(pat_bus.pat_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load L=1000 R=0101 in IDLE, then start at period 4.
        offer(1'b1, 4'b1000, 4'b0101);
        step();
        offer(1'b0, 4'b0000, 4'b0000);
        check("idle_ready", 32'(pat_bus.pat_ready), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'({busy, beat_fire}), 32'b10);
        beat("t1_b0", 1, 2'd0, 1'b1, 1'b0);
        check("t1_barcnt0", 32'(bar_cnt), 32'd0);
        beat("t1_b1", 4, 2'd1, 1'b0, 1'b1);
        beat("t1_b2", 4, 2'd2, 1'b0, 1'b0);
        beat("t1_b3", 4, 2'd3, 1'b0, 1'b1);
        beat("t2_b0", 4, 2'd0, 1'b1, 1'b0);
        check("t1_barcnt1", 32'(bar_cnt), 32'd1);
        beat("t2_b1", 4, 2'd1, 1'b0, 1'b1);

        // Offer L=1111 at idx1: accepted at once, held until next beat one.
        offer(1'b1, 4'b1111, 4'b0101);
        check("t2_ready_pre", 32'(pat_bus.pat_ready), 32'd1);
        step();
        offer(1'b0, 4'b0000, 4'b0000);
        check("t2_ready_full", 32'(pat_bus.pat_ready), 32'd0);
        beat("t2_b2", 3, 2'd2, 1'b0, 1'b0);
        beat("t2_b3", 4, 2'd3, 1'b0, 1'b1);
        check("t2_ready_hold", 32'(pat_bus.pat_ready), 32'd0);
        beat("t3_b0_swap", 4, 2'd0, 1'b1, 1'b0);
        check("t2_ready_back", 32'(pat_bus.pat_ready), 32'd1);
        check("t2_barcnt", 32'(bar_cnt), 32'd2);
        beat("t3_b1", 4, 2'd1, 1'b1, 1'b1);

        // Second pattern while pending is full is held off until the swap.
        offer(1'b1, 4'b0011, 4'b1000);
        step();
        offer(1'b1, 4'b0110, 4'b0001);
        check("t3_ready_full", 32'(pat_bus.pat_ready), 32'd0);
        beat("t3_b2", 3, 2'd2, 1'b1, 1'b0);
        beat("t3_b3", 4, 2'd3, 1'b1, 1'b1);
        beat("t4_b0_swap", 4, 2'd0, 1'b0, 1'b1);
        check("t3_ready_after_swap", 32'(pat_bus.pat_ready), 32'd1);
        step();
        offer(1'b0, 4'b0000, 4'b0000);
        check("t3_second_taken", 32'(pat_bus.pat_ready), 32'd0);
        beat("t4_b1", 3, 2'd1, 1'b0, 1'b0);
        check("t3_barcnt", 32'(bar_cnt), 32'd3);

        // Period 4 -> 2 mid-bar: new spacing starts after the next fire.
        period = 16'd2;
        beat("p2_b2", 4, 2'd2, 1'b1, 1'b0);
        beat("p2_b3", 2, 2'd3, 1'b1, 1'b0);
        beat("p2_b0", 2, 2'd0, 1'b0, 1'b0);
        check("p2_barcnt", 32'(bar_cnt), 32'd4);

        // Period 0 behaves as 1, then period 1.
        period = 16'd0;
        beat("p0_b1", 2, 2'd1, 1'b1, 1'b0);
        beat("p0_b2", 1, 2'd2, 1'b1, 1'b0);
        beat("p0_b3", 1, 2'd3, 1'b0, 1'b1);
        beat("p0_b0", 1, 2'd0, 1'b0, 1'b0);
        check("p0_barcnt", 32'(bar_cnt), 32'd5);
        period = 16'd1;
        beat("p1_b1", 1, 2'd1, 1'b1, 1'b0);
        beat("p1_b2", 1, 2'd2, 1'b1, 1'b0);

        // Stop mid-bar: no pulse in the stop cycle, back to IDLE.
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_cycle", 32'({busy, beat_fire, left_hit, right_hit, bar_start}), 32'd0);
        step();
        check("idle_quiet", 32'({busy, beat_fire, left_hit, right_hit, bar_start}), 32'd0);

        // start and stop together in IDLE: stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("startstop_1", 32'({busy, beat_fire}), 32'd0);
        step();
        check("startstop_2", 32'({busy, beat_fire}), 32'd0);
        start = 1'b0;
        stop  = 1'b0;

        // Restart at period 1 and run 257 bars: bar_cnt wraps 255 -> 0.
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", 32'({busy, bar_cnt}), 32'h100);
        beat("wrap_bar1", 1, 2'd0, 1'b0, 1'b0);
        check("wrap_barcnt0", 32'(bar_cnt), 32'd0);
        all_fire = 1'b1;
        for (int b = 0; b < 255; b++) begin
            repeat (4) begin
                step();
                all_fire = all_fire & beat_fire;
            end
        end
        check("wrap_every_cycle", 32'(all_fire), 32'd1);
        check("wrap_barcnt255", 32'(bar_cnt), 32'd255);
        beat("wrap_w1", 1, 2'd1, 1'b1, 1'b0);
        beat("wrap_w2", 1, 2'd2, 1'b1, 1'b0);
        beat("wrap_w3", 1, 2'd3, 1'b0, 1'b1);
        beat("wrap_w0", 1, 2'd0, 1'b0, 1'b0);
        check("wrap_barcnt_0", 32'(bar_cnt), 32'd0);

        // Pending survives stop and is applied on the first beat after start.
        offer(1'b1, 4'b1001, 4'b0110);
        step();
        offer(1'b0, 4'b0000, 4'b0000);
        check("keep_ready_full", 32'(pat_bus.pat_ready), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("keep_idle", 32'({busy, pat_bus.pat_ready}), 32'b01);
        start = 1'b1;
        step();
        start = 1'b0;
        check("keep_run_full", 32'({busy, pat_bus.pat_ready}), 32'b10);
        beat("keep_b0", 1, 2'd0, 1'b1, 1'b0);
        check("keep_barcnt", 32'(bar_cnt), 32'd0);
        check("keep_ready_back", 32'(pat_bus.pat_ready), 32'd1);

        // Asynchronous reset mid-beat with a pending pattern.
        period = 16'd8;
        offer(1'b1, 4'b1111, 4'b1111);
        step();
        offer(1'b0, 4'b0000, 4'b0000);
        check("prerst_fire", 32'({beat_fire, beat_idx, left_hit, right_hit, bar_start}),
              32'b101010);
        check("prerst_ready", 32'(pat_bus.pat_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({busy, beat_fire, beat_idx, left_hit, right_hit,
                                     bar_start, bar_cnt, pat_bus.pat_ready}), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Pending was discarded: first beat plays the all-zero active pattern.
        period = 16'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("postrst_ready", 32'(pat_bus.pat_ready), 32'd1);
        beat("postrst_b0", 1, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
